delayline_mc: RTL and testbench

DELAYLINE_MC -- requirements
Module: delayline_mc

---
 rtl/delayline_mc.sv | 98 +++++++++
 tb/tb_delayline_mc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/delayline_mc.sv
// Multi-channel delay line with a runtime-selectable delay of 1..DEPTH enabled edges.
// Optional DELAYLINE_MC_MASK_EN zeroes out whenever out_valid is low.
module delayline_mc #(
    parameter int BIT_WIDTH  = 8,
    parameter int CHANNELS   = 3,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DEPTH_LOG2-1:0]         latency,
    input  logic [CHANNELS*BIT_WIDTH-1:0] in,
    output logic [CHANNELS*BIT_WIDTH-1:0] out,
    output logic                          out_valid,
    output logic                          lat_changed
);
    localparam int W     = CHANNELS * BIT_WIDTH;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int FW    = DEPTH_LOG2 + 1;

    typedef enum logic {FILL, RUN} state_t;

    state_t                r_state, w_state_nxt;
    logic [DEPTH_LOG2-1:0] r_lat_q;
    logic [DEPTH_LOG2-1:0] r_index;
    logic [FW-1:0]         r_fill_cnt, w_fill_nxt;
    logic                  r_out_valid, w_valid_nxt;
    logic                  r_lat_changed;
    logic [W-1:0]          r_out;
    logic                  w_change;
    logic [FW-1:0]         w_lat_p1;

    // All channels share one word per address, which keeps them index-aligned.
    logic [W-1:0] r_mem [DEPTH] = '{default: '0};

    assign w_change = enable && (latency != r_lat_q);
    assign w_lat_p1 = {1'b0, r_lat_q} + FW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill_cnt;
        w_valid_nxt = r_out_valid;
        if (w_change) begin
            w_state_nxt = FILL;
            w_fill_nxt  = '0;
            w_valid_nxt = 1'b0;
        end else if (enable && r_state == FILL) begin
            // The slot read this edge was written lat_q+1 edges ago once fill_cnt reaches lat_q+1.
            if (r_fill_cnt == w_lat_p1) begin
                w_state_nxt = RUN;
                w_valid_nxt = 1'b1;
            end else begin
                w_fill_nxt = r_fill_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= FILL;
            r_lat_q       <= '0;
            r_index       <= '0;
            r_fill_cnt    <= '0;
            r_out_valid   <= 1'b0;
            r_lat_changed <= 1'b0;
            r_out         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_fill_cnt    <= w_fill_nxt;
            r_out_valid   <= w_valid_nxt;
            r_lat_changed <= w_change;
            if (enable) begin
                r_lat_q <= latency;
                if (w_change) begin
                    r_index <= '0;
                end else begin
                    r_out   <= r_mem[r_index];
                    r_index <= (r_index == r_lat_q) ? '0 : r_index + DEPTH_LOG2'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enable && !w_change && !reset) begin
            r_mem[r_index] <= in;
        end
    end

`ifdef DELAYLINE_MC_MASK_EN
    assign out = r_out_valid ? r_out : '0;
`else
    assign out = r_out;
`endif
    assign out_valid   = r_out_valid;
    assign lat_changed = r_lat_changed;

endmodule

// File: tb/tb_delayline_mc.sv
// Self-checking bench for delayline_mc against a queue-based model of the delay line.
module tb_delayline_mc;
    localparam int BW = 8;
    localparam int CH = 3;
    localparam int DL = 5;
    localparam int W  = BW * CH;
`ifdef DELAYLINE_MC_MASK_EN
    localparam bit MASK = 1'b1;
`else
    localparam bit MASK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [DL-1:0] latency;
    logic [W-1:0]  din;
    logic [W-1:0]  dout;
    logic          out_valid;
    logic          lat_changed;

    delayline_mc #(.BIT_WIDTH(BW), .CHANNELS(CH), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .reset(reset), .enable(enable), .latency(latency),
        .in(din), .out(dout), .out_valid(out_valid), .lat_changed(lat_changed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: inputs accepted since the last restart; delay = lat+1 accepted edges.
    int           m_lat;
    int           m_cnt;
    logic [W-1:0] hist[$];
    logic         e_valid;
    logic         e_lc;
    logic [W-1:0] e_out;

    task automatic model_reset();
        m_lat = 0; m_cnt = 0; hist.delete();
        e_valid = 1'b0; e_lc = 1'b0; e_out = '0;
    endtask

    task automatic step(input logic en, input int lat, input logic [W-1:0] d);
        enable = en; latency = lat[DL-1:0]; din = d;
        @(posedge clk);
        if (!en) begin
            e_lc = 1'b0;
        end else if (lat != m_lat) begin
            m_lat = lat; m_cnt = 0; hist.delete();
            e_valid = 1'b0; e_lc = 1'b1;
        end else begin
            e_lc = 1'b0;
            hist.push_back(d);
            m_cnt++;
            if (hist.size() > 40) void'(hist.pop_front());
            if (m_cnt >= m_lat + 2) begin
                e_valid = 1'b1;
                e_out = hist[hist.size() - 2 - m_lat];
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] want;
        reset = 1'b1; enable = 1'b0; latency = '0; din = '0;
        model_reset();
        #1;
        checks += 3;
        if (dout !== '0) begin errors++; $display("FAIL reset_out_async: got %h want 0", dout); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        if (lat_changed !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", lat_changed); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        want = '0;
        checks++;
        if (dout !== want) begin errors++; $display("FAIL reset_out_held: got %h want %h", dout, want); end
    endtask

    task automatic test_latency4();
        logic [W-1:0] want;
        int rise = -1;
        for (int k = 1; k <= 20; k++) begin
            step(1'b1, 4, W'(k));
            if (rise < 0 && out_valid === 1'b1) rise = k;
            checks += 2;
            if (lat_changed !== e_lc) begin errors++; $display("FAIL lat4_pulse e%0d: got %b want %b", k, lat_changed, e_lc); end
            if (out_valid !== e_valid) begin errors++; $display("FAIL lat4_valid e%0d: got %b want %b", k, out_valid, e_valid); end
            if (e_valid || MASK) begin
                want = e_valid ? e_out : '0;
                checks++;
                if (dout !== want) begin errors++; $display("FAIL lat4_out e%0d: got %h want %h", k, dout, want); end
            end
        end
        checks++;
        if (rise !== 7) begin errors++; $display("FAIL lat4_rise_edge: got %0d want 7", rise); end
    endtask

    task automatic test_lat0_channels();
        logic [W-1:0] want;
        logic [7:0] r;
        for (int k = 0; k < 12; k++) begin
            r = 8'(k);
            step(1'b1, 0, {8'h11 + r, 8'h22 + r, 8'h33 + r});
            checks += 2;
            if (lat_changed !== e_lc) begin errors++; $display("FAIL lat0_pulse e%0d: got %b want %b", k, lat_changed, e_lc); end
            if (out_valid !== e_valid) begin errors++; $display("FAIL lat0_valid e%0d: got %b want %b", k, out_valid, e_valid); end
            if (e_valid || MASK) begin
                want = e_valid ? e_out : '0;
                checks++;
                if (dout !== want) begin errors++; $display("FAIL lat0_out e%0d: got %h want %h", k, dout, want); end
            end
        end
    endtask

    task automatic test_full_depth();
        logic [W-1:0] want;
        for (int k = 0; k < 101; k++) begin
            step(1'b1, 31, W'($urandom));
            checks += 2;
            if (lat_changed !== e_lc) begin errors++; $display("FAIL depth_pulse e%0d: got %b want %b", k, lat_changed, e_lc); end
            if (out_valid !== e_valid) begin errors++; $display("FAIL depth_valid e%0d: got %b want %b", k, out_valid, e_valid); end
            if (e_valid || MASK) begin
                want = e_valid ? e_out : '0;
                checks++;
                if (dout !== want) begin errors++; $display("FAIL depth_out e%0d: got %h want %h", k, dout, want); end
            end
        end
    endtask

    task automatic test_lat_change();
        logic [W-1:0] want;
        int rise = -1;
        int lat;
        for (int k = 0; k < 26; k++) begin
            lat = (k < 15) ? 4 : 2;
            step(1'b1, lat, W'($urandom));
            if (k >= 15 && rise < 0 && out_valid === 1'b1) rise = k - 15;
            checks += 2;
            if (lat_changed !== e_lc) begin errors++; $display("FAIL chg_pulse e%0d: got %b want %b", k, lat_changed, e_lc); end
            if (out_valid !== e_valid) begin errors++; $display("FAIL chg_valid e%0d: got %b want %b", k, out_valid, e_valid); end
            if (e_valid || MASK) begin
                want = e_valid ? e_out : '0;
                checks++;
                if (dout !== want) begin errors++; $display("FAIL chg_out e%0d: got %h want %h", k, dout, want); end
            end
        end
        checks++;
        if (rise !== 4) begin errors++; $display("FAIL chg_revalid_edges: got %0d want 4", rise); end
    endtask

    task automatic test_enable_toggle();
        logic [W-1:0] want;
        for (int k = 0; k < 200; k++) begin
            step(1'($urandom_range(0, 1)), 7, W'($urandom));
            checks += 2;
            if (lat_changed !== e_lc) begin errors++; $display("FAIL en_pulse e%0d: got %b want %b", k, lat_changed, e_lc); end
            if (out_valid !== e_valid) begin errors++; $display("FAIL en_valid e%0d: got %b want %b", k, out_valid, e_valid); end
            if (e_valid || MASK) begin
                want = e_valid ? e_out : '0;
                checks++;
                if (dout !== want) begin errors++; $display("FAIL en_out e%0d: got %h want %h", k, dout, want); end
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [W-1:0] want;
        for (int k = 0; k < 6; k++) step(1'b1, 10, W'($urandom));
        reset = 1'b1;
        #1;
        checks += 3;
        if (dout !== '0) begin errors++; $display("FAIL midrst_out: got %h want 0", dout); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        if (lat_changed !== 1'b0) begin errors++; $display("FAIL midrst_pulse: got %b want 0", lat_changed); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 25; k++) begin
            step(1'b1, 10, W'($urandom));
            checks += 2;
            if (lat_changed !== e_lc) begin errors++; $display("FAIL refill_pulse e%0d: got %b want %b", k, lat_changed, e_lc); end
            if (out_valid !== e_valid) begin errors++; $display("FAIL refill_valid e%0d: got %b want %b", k, out_valid, e_valid); end
            if (e_valid || MASK) begin
                want = e_valid ? e_out : '0;
                checks++;
                if (dout !== want) begin errors++; $display("FAIL refill_out e%0d: got %h want %h", k, dout, want); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency4();
        test_lat0_channels();
        test_full_depth();
        test_lat_change();
        test_enable_toggle();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
